// File: rtl/rv_rr_arbiter_if.sv
// Ready/valid bundle between N_REQ requesters, the round-robin arbiter and its single downstream sink.
// master = requester/sink side, slave = arbiter side.
interface rv_rr_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_REQ  = 4
);
  localparam int unsigned SRC_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        in_valid;
  logic [N_REQ*DATA_W-1:0] in_data;
  logic [N_REQ-1:0]        in_last;
  logic [N_REQ-1:0]        in_ready;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic                    out_last;
  logic [SRC_W-1:0]        out_src;
  logic                    out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_src
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_src
  );
endinterface

// File: rtl/rv_rr_arbiter.sv
// Round-robin arbiter with packet locking that merges N_REQ ready/valid streams into one
// registered output stage (1-cycle latency, one beat per cycle).
module rv_rr_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_REQ  = 4
) (
  input  logic            clk,
  input  logic            rst,
  rv_rr_arbiter_if.slave  bus
);
  localparam int unsigned SRC_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N_REQ - 1);

  typedef enum logic {S_IDLE, S_LOCKED} state_e;

  state_e              state_q, state_d;
  logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]    owner_q, owner_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [SRC_W-1:0]    out_src_q, out_src_d;

  logic [DATA_W-1:0]   data_arr [N_REQ];
  logic                sel_found_c;
  logic [SRC_W-1:0]    sel_idx_c;
  logic [SRC_W-1:0]    cand_c;
  logic                can_load_c;
  logic                grant_vld_c;
  logic [SRC_W-1:0]    grant_idx_c;
  logic [SRC_W-1:0]    next_idx_c;
  logic [N_REQ-1:0]    ready_c;
  logic                xfer_c;

  for (genvar g = 0; g < N_REQ; g++) begin : g_split
    assign data_arr[g] = bus.in_data[g*DATA_W +: DATA_W];
  end

  // Search downward so the candidate closest to rr_ptr (in wrap order) is assigned last and wins.
  always_comb begin
    sel_found_c = 1'b0;
    sel_idx_c   = rr_ptr_q;
    cand_c      = '0;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      cand_c = SRC_W'((32'(rr_ptr_q) + k - 32'd1) % N_REQ);
      if (bus.in_valid[cand_c]) begin
        sel_found_c = 1'b1;
        sel_idx_c   = cand_c;
      end
    end
  end

  // Next-state and grant logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    grant_vld_c = 1'b0;
    grant_idx_c = sel_idx_c;
    ready_c     = '0;
    can_load_c  = !out_valid_q || bus.out_ready;

    case (state_q)
      S_IDLE: begin
        grant_vld_c = sel_found_c;
        grant_idx_c = sel_idx_c;
      end
      S_LOCKED: begin
        grant_vld_c = 1'b1;
        grant_idx_c = owner_q;
      end
      default: begin
        grant_vld_c = 1'b0;
      end
    endcase

    if (grant_vld_c && can_load_c && !rst) begin
      ready_c[grant_idx_c] = 1'b1;
    end
    xfer_c     = bus.in_valid[grant_idx_c] && ready_c[grant_idx_c];
    next_idx_c = (grant_idx_c == LAST_IDX) ? '0 : grant_idx_c + SRC_W'(1);

    if (xfer_c) begin
      out_valid_d = 1'b1;
      out_data_d  = data_arr[grant_idx_c];
      out_last_d  = bus.in_last[grant_idx_c];
      out_src_d   = grant_idx_c;
      if (bus.in_last[grant_idx_c]) begin
        state_d  = S_IDLE;
        rr_ptr_d = next_idx_c;
      end else begin
        state_d  = S_LOCKED;
        owner_d  = grant_idx_c;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_rv_rr_arbiter.sv
// Self-checking bench for rv_rr_arbiter: per-requester source queues feed the DUT, and an
// expected-output scoreboard is compared on every output handshake.
module tb_rv_rr_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic [1:0]    s;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  beat_t srcq [NR][$];
  exp_t  sb [$];
  logic [NR-1:0] en;

  rv_rr_arbiter_if #(.DATA_W(DW), .N_REQ(NR)) bus ();

  rv_rr_arbiter #(.DATA_W(DW), .N_REQ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (en[i] && srcq[i].size() > 0) begin
        bus.in_valid[i]          = 1'b1;
        bus.in_data[i*DW +: DW]  = srcq[i][0].d;
        bus.in_last[i]           = srcq[i][0].l;
      end else begin
        bus.in_valid[i]          = 1'b0;
        bus.in_data[i*DW +: DW]  = '0;
        bus.in_last[i]           = 1'b0;
      end
    end
  endtask

  task automatic push_src(input int r, input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    srcq[r].push_back(b);
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic l, input logic [1:0] s);
    exp_t e;
    e.d = d;
    e.l = l;
    e.s = s;
    sb.push_back(e);
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) srcq[i].delete();
    sb.delete();
  endtask

  // One clock: settle, record handshakes and score the output beat, then advance the sources.
  task automatic step();
    logic [NR-1:0] fire;
    exp_t e;
    #1;
    fire = bus.in_valid & bus.in_ready;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && rst === 1'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL out_beat unexpected: got data=%h last=%b src=%0d, required none",
                 bus.out_data, bus.out_last, bus.out_src);
      end else begin
        e = sb.pop_front();
        if (bus.out_data !== e.d || bus.out_last !== e.l || bus.out_src !== e.s) begin
          errors++;
          $display("FAIL out_beat: got data=%h last=%b src=%0d, required data=%h last=%b src=%0d",
                   bus.out_data, bus.out_last, bus.out_src, e.d, e.l, e.s);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (fire[i] === 1'b1 && srcq[i].size() > 0) void'(srcq[i].pop_front());
    end
    drive();
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (sb.size() != 0 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats outstanding, required 0", sb.size());
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    en = '1;
    clear_all();
    drive();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = '1;
    bus.out_ready = 1'b1;
    clear_all();
    push_src(0, 32'h5555_5555, 1'b1);
    drive();
    step();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
    checks++;
    if (bus.out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h required 0", bus.out_data); end
    checks++;
    if (bus.out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b required 0", bus.out_last); end
    checks++;
    if (bus.out_src !== 2'd0) begin errors++; $display("FAIL rst_out_src: got %0d required 0", bus.out_src); end
    checks++;
    if (bus.in_ready !== 4'b0000) begin errors++; $display("FAIL rst_in_ready: got %b required 0000", bus.in_ready); end
    #1;
    rst = 1'b0;
    clear_all();
    drive();
  endtask

  task automatic test_single();
    reset_dut();
    bus.out_ready = 1'b1;
    push_src(0, 32'h1111_1111, 1'b1);
    push_exp(32'h1111_1111, 1'b1, 2'd0);
    drive();
    #1;
    checks++;
    if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b required 0001", bus.in_ready); end
    step();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1111_1111 || bus.out_src !== 2'd0 || bus.out_last !== 1'b1) begin
      errors++;
      $display("FAIL single_out: got v=%b d=%h s=%0d l=%b required v=1 d=11111111 s=0 l=1",
               bus.out_valid, bus.out_data, bus.out_src, bus.out_last);
    end
    drain();
  endtask

  task automatic test_round_robin();
    reset_dut();
    bus.out_ready = 1'b1;
    push_src(0, 32'hA0, 1'b1);
    push_src(0, 32'hA4, 1'b1);
    push_src(1, 32'hA1, 1'b1);
    push_src(2, 32'hA2, 1'b1);
    push_src(3, 32'hA3, 1'b1);
    push_exp(32'hA0, 1'b1, 2'd0);
    push_exp(32'hA1, 1'b1, 2'd1);
    push_exp(32'hA2, 1'b1, 2'd2);
    push_exp(32'hA3, 1'b1, 2'd3);
    push_exp(32'hA4, 1'b1, 2'd0);
    drive();
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_src !== 2'(i % 4)) begin
        errors++;
        $display("FAIL rr_order[%0d]: got v=%b src=%0d required v=1 src=%0d", i, bus.out_valid, bus.out_src, i % 4);
      end
    end
    drain();
  endtask

  task automatic test_lock();
    reset_dut();
    bus.out_ready = 1'b1;
    push_src(1, 32'hB0, 1'b0);
    push_src(1, 32'hB1, 1'b0);
    push_src(1, 32'hB2, 1'b1);
    push_src(2, 32'hC0, 1'b1);
    push_src(2, 32'hC1, 1'b1);
    push_exp(32'hB0, 1'b0, 2'd1);
    push_exp(32'hB1, 1'b0, 2'd1);
    push_exp(32'hB2, 1'b1, 2'd1);
    push_exp(32'hC0, 1'b1, 2'd2);
    push_exp(32'hC1, 1'b1, 2'd2);
    drive();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.in_ready !== 4'b0010) begin
        errors++;
        $display("FAIL lock_ready[%0d]: got %b required 0010", i, bus.in_ready);
      end
      step();
    end
    #1;
    checks++;
    if (bus.in_ready !== 4'b0100) begin errors++; $display("FAIL lock_switch: got %b required 0100", bus.in_ready); end
    drain();
  endtask

  task automatic test_backpressure();
    reset_dut();
    push_src(0, 32'hDEAD_BEEF, 1'b1);
    push_src(1, 32'h1234_5678, 1'b1);
    push_exp(32'hDEAD_BEEF, 1'b1, 2'd0);
    push_exp(32'h1234_5678, 1'b1, 2'd1);
    drive();
    #1;
    checks++;
    if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL bp_first_ready: got %b required 0001", bus.in_ready); end
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hDEAD_BEEF || bus.in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h rdy=%b required v=1 d=deadbeef rdy=0000",
                 i, bus.out_valid, bus.out_data, bus.in_ready);
      end
    end
    #1;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b required 0010", bus.in_ready); end
    step();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1234_5678 || bus.out_src !== 2'd1) begin
      errors++;
      $display("FAIL bp_next: got v=%b d=%h s=%0d required v=1 d=12345678 s=1", bus.out_valid, bus.out_data, bus.out_src);
    end
    drain();
  endtask

  task automatic test_lock_gap();
    reset_dut();
    bus.out_ready = 1'b1;
    push_src(2, 32'hF0, 1'b1);
    push_exp(32'hF0, 1'b1, 2'd2);
    drive();
    step();
    push_src(3, 32'hD0, 1'b0);
    push_src(3, 32'hD1, 1'b0);
    push_src(3, 32'hD2, 1'b1);
    push_src(0, 32'hE0, 1'b1);
    push_exp(32'hD0, 1'b0, 2'd3);
    push_exp(32'hD1, 1'b0, 2'd3);
    push_exp(32'hD2, 1'b1, 2'd3);
    push_exp(32'hE0, 1'b1, 2'd0);
    drive();
    #1;
    checks++;
    if (bus.in_ready !== 4'b1000) begin errors++; $display("FAIL gap_first: got %b required 1000", bus.in_ready); end
    step();
    en[3] = 1'b0;
    drive();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (bus.in_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL gap_stall[%0d]: got in_ready=%b required bit0=0", i, bus.in_ready);
      end
      step();
    end
    en[3] = 1'b1;
    drive();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (bus.in_ready !== 4'b1000) begin
        errors++;
        $display("FAIL gap_resume[%0d]: got %b required 1000", i, bus.in_ready);
      end
      step();
    end
    #1;
    checks++;
    if (bus.in_ready !== 4'b0001) begin errors++; $display("FAIL gap_wrap: got %b required 0001", bus.in_ready); end
    drain();
  endtask

  task automatic test_reset_locked();
    reset_dut();
    push_src(1, 32'h6000_0000, 1'b0);
    push_src(1, 32'h6000_0001, 1'b0);
    drive();
    step();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rl_buffered: got v=%b rdy=%b required v=1 rdy=0000", bus.out_valid, bus.in_ready);
    end
    #1;
    rst = 1'b1;
    clear_all();
    drive();
    step();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rl_reset: got v=%b rdy=%b required v=0 rdy=0000", bus.out_valid, bus.in_ready);
    end
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    push_src(2, 32'h7777_7777, 1'b1);
    push_exp(32'h7777_7777, 1'b1, 2'd2);
    drive();
    #1;
    checks++;
    if (bus.in_ready !== 4'b0100) begin errors++; $display("FAIL rl_regrant: got %b required 0100", bus.in_ready); end
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    en = '1;
    bus.out_ready = 1'b0;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.in_last = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_lock_gap();
    test_reset_locked();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_rr_arbiter.md
# rv_rr_arbiter

Round-robin arbiter that shares one ready/valid output stream between N_REQ requesters, with packet locking and a registered single-entry output stage. It sits in front of the 32-bit ready/valid pipeline register chain and decides which source drives it. Packets are delimited by a last flag and are never interleaved. The output register gives full throughput: one beat per cycle with 1-cycle latency.

## Interface
- DATA_W, 32, beat width.
- N_REQ, 4, number of requesters (≥2).
- SRC_W, max(1, $clog2(N_REQ)), derived width of out_src.

- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  N_REQ  per-requester valid.
- in_data  in  N_REQ*DATA_W  requester i at [i*DATA_W +: DATA_W].
- in_last  in  N_REQ  final beat of a packet.
- in_ready  out  N_REQ  per-requester ready; at most one bit high per cycle.
- out_valid  out  1  output beat valid.
- out_data  out  DATA_W  output beat.
- out_last  out  1  last flag of output beat.
- out_src  out  SRC_W  index of the requester that supplied the beat.
- out_ready  in  1  downstream ready.

## Operation
- Output register holds out_valid/out_data/out_last/out_src. can_load = !out_valid || out_ready.
- A beat transfers from requester i when in_valid[i] && in_ready[i]. It is captured into the output register on that edge.
- With no transfer, if out_ready is high the register clears out_valid. Otherwise it holds all four outputs stable.
- State machine IDLE / LOCKED, plus an rr_ptr (SRC_W bits) and an owner (SRC_W bits).
- IDLE:
  - sel = first i with in_valid[i], searching from rr_ptr upward with wrap mod N_REQ.
  - in_ready[sel] = can_load; all other in_ready = 0. If no valid, all in_ready = 0.
  - On transfer with in_last=1: stay IDLE, rr_ptr = (sel+1) mod N_REQ.
  - On transfer with in_last=0: go LOCKED, owner = sel.
- LOCKED:
  - in_ready[owner] = can_load; all others 0.
  - If the owner drops in_valid mid-packet, the arbiter stalls (bubbles) and does not switch requesters.
  - On transfer with in_last=1: go IDLE, rr_ptr = (owner+1) mod N_REQ.
- A single-beat packet (in_last=1 on the first beat) never enters LOCKED.
- in_ready may depend on in_valid. Requesters must not make in_valid depend on in_ready.
- Wrap: rr_ptr increments modulo N_REQ, including non-power-of-2 N_REQ (e.g. 3: 2→0).

## Timing
- Reset (rst high at an edge): out_valid=0, out_data=0, out_last=0, out_src=0, state=IDLE, rr_ptr=0, owner=0. in_ready is all 0 while rst is high.
- Reset mid-packet: the partial packet is abandoned, the buffered beat is dropped, and the next grant starts the search from requester 0.
- Latency: a beat accepted at edge k appears on out_* after edge k.
- Throughput: 1 beat/cycle while out_ready is held high. Load and drain in the same cycle are allowed (can_load via out_ready).
- Backpressure: out_ready=0 with out_valid=1 sets in_ready all 0 in the same cycle. No beat is lost or duplicated.
- Grant switch after a packet end: the new requester may transfer in the cycle immediately after the last beat's transfer, with no dead cycle.
- Simultaneous requests in IDLE resolve in the same cycle by rr_ptr order. No priority to low indices beyond the pointer.

## Test plan
- Reset, then in_valid[0]=1, data 0x1111_1111, last=1, out_ready=1 → in_ready[0]=1 in cycle 0. Next cycle out_valid=1, out_data=0x1111_1111, out_src=0, out_last=1.
- All 4 requesters valid with single-beat packets 0xA0..0xA3, out_ready=1 → output order src 0,1,2,3,0 at one beat per cycle.
- Req1 sends 3-beat packet 0xB0,0xB1,0xB2 (last on 0xB2) while req2 is continuously valid → out_src=1 for three consecutive beats, then req2. Req2's in_ready stays 0 throughout.
- Backpressure: out_ready=0 with 0xDEAD_BEEF buffered → out_data is held and in_ready is all 0. Raise out_ready → 0xDEAD_BEEF leaves, and the next pending beat loads in the same cycle.
- Lock with a gap: owner req3 drops valid for 2 cycles mid-packet while req0 is valid → no req0 beats appear until req3's last beat transfers, then rr_ptr wraps to 0.
- Assert rst while LOCKED with a beat buffered → next cycle out_valid=0, state IDLE. A subsequent request from req2 only is granted immediately.
